// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - sizing helpers and constants for the pipelined Wallace multiplier
// Purpose: reduction-tree depth, rank split across pipeline stages and the
//          Baugh-Wooley correction constant.
// Ports:   none (package).
package wallace_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int PROD_W    = 2 * DEF_WIDTH;

  // Rows left after n 3:2 levels, starting from width partial-product rows
  // plus one correction-constant row.
  function automatic int rows_at(input int width, input int n);
    int r;
    r = width + 1;
    for (int i = 0; i < n; i++) r = 2 * (r / 3) + (r % 3);
    return r;
  endfunction

  // Number of 3:2 levels needed to bring the rows down to two.
  function automatic int tree_levels(input int width);
    int r;
    int n;
    r = width + 1;
    n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      n++;
    end
    return n;
  endfunction

  // Largest number of tree levels any register rank carries; the last rank
  // holds only the carry-propagate adder.
  function automatic int levels_per_stage(input int width, input int stages);
    if (stages <= 1) return tree_levels(width);
    return (tree_levels(width) + stages - 2) / (stages - 1);
  endfunction

  // True when completing tree level n closes a register rank. Rank k ends
  // after floor(k*L/(stages-1)) levels, spreading the levels evenly.
  function automatic bit rank_end(input int width, input int stages, input int n);
    bit hit;
    hit = 1'b0;
    for (int k = 1; k < stages; k++)
      if ((k * tree_levels(width)) / (stages - 1) == n) hit = 1'b1;
    return hit;
  endfunction

  // Folding the two negative Baugh-Wooley row/column sums into constants
  // leaves 2^(2w-1) + 2^w modulo 2^(2w).
  function automatic logic [127:0] bw_correction(input int width);
    return (128'd1 << (2 * width - 1)) | (128'd1 << width);
  endfunction

endpackage

// File: rtl/wallace_pipe_mult_if.sv
// rtl/wallace_pipe_mult_if.sv - operand/product handshake bundle for wallace_pipe_mult
// Purpose: groups the input and output valid/ready channels.
// Signals: in_valid/in_ready/a/b/signed_mode (operand channel),
//          out_valid/out_ready/out (product channel),
//          ovf only when WALLACE_PIPE_OVF_EN is defined.
// Modports: master = operand issuer + product consumer, slave = multiplier.
interface wallace_pipe_mult_if #(parameter int WIDTH = 32);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;
`ifdef WALLACE_PIPE_OVF_EN
  logic                 ovf;

  modport master (output in_valid, a, b, signed_mode, out_ready,
                  input  in_ready, out_valid, out, ovf);
  modport slave  (input  in_valid, a, b, signed_mode, out_ready,
                  output in_ready, out_valid, out, ovf);
`else
  modport master (output in_valid, a, b, signed_mode, out_ready,
                  input  in_ready, out_valid, out);
  modport slave  (input  in_valid, a, b, signed_mode, out_ready,
                  output in_ready, out_valid, out);
`endif
endinterface

// File: rtl/wallace_pipe_mult_csa_row.sv
// rtl/wallace_pipe_mult_csa_row.sv - one row of full adders (3:2 compressor)
// Purpose: reduces three W-bit vectors to a sum and a carry vector.
// Ports: x, y, z (in, W) addends; sum (out, W) bitwise sum;
//        carry (out, W) majority bits already shifted up one place, MSB
//        carry dropped because the product is kept modulo 2^W.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_pipe_mult.sv
// rtl/wallace_pipe_mult.sv - pipelined signed/unsigned Wallace-tree multiplier
// Purpose: full-width product of a*b through a registered 3:2 reduction tree
//          and a final carry-propagate adder, valid/ready on both sides.
// Ports: clk, rst_n (async, active low); io (wallace_pipe_mult_if.slave):
//        operand channel in_valid/in_ready/a/b/signed_mode, product channel
//        out_valid/out_ready/out. Macro WALLACE_PIPE_OVF_EN adds io.ovf.
module wallace_pipe_mult
  import wallace_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  wallace_pipe_mult_if.slave io
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;
  localparam int L  = tree_levels(WIDTH);
  localparam logic [PW-1:0] CORR = PW'(bw_correction(WIDTH));

  logic          advance;
  logic          out_valid_q;
  logic [PW-1:0] out_q;
  logic [PW-1:0] cpa;
  logic          last_valid;

  // The whole pipe moves together; it only stops for an unaccepted product.
  assign advance      = !out_valid_q || io.out_ready;
  assign io.in_ready  = advance;
  assign io.out_valid = out_valid_q;
  assign io.out       = out_q;

  // Partial products; in signed mode the terms pairing exactly one sign bit
  // are inverted and the correction constant becomes an extra row.
  logic [NR-1:0][PW-1:0] pp;
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[i][i+j] = (io.a[j] & io.b[i]) ^ (io.signed_mode & ((i == WIDTH-1) != (j == WIDTH-1)));
    pp[WIDTH] = io.signed_mode ? CORR : '0;
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int RI = rows_at(WIDTH, l);
    localparam int RO = rows_at(WIDTH, l + 1);
    localparam int G  = RI / 3;
    logic [RI-1:0][PW-1:0] din;
    logic [RO-1:0][PW-1:0] nxt;
    logic [RO-1:0][PW-1:0] dout;

    if (l == 0) begin : g_src
      assign din = pp;
    end else begin : g_src
      assign din = g_lvl[l-1].dout;
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_row #(.W(PW)) u_csa (
        .x     (din[3*g]),
        .y     (din[3*g+1]),
        .z     (din[3*g+2]),
        .sum   (nxt[2*g]),
        .carry (nxt[2*g+1])
      );
    end

    // Rows that do not fill a group of three pass straight to the next level.
    for (genvar k = 0; k < RI - 3*G; k++) begin : g_pass
      assign nxt[2*G+k] = din[3*G+k];
    end

    if (rank_end(WIDTH, STAGES, l + 1)) begin : g_rank
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dout <= '0;
        else if (advance) dout <= nxt;
      end
    end else begin : g_wire
      assign dout = nxt;
    end
  end

  assign cpa = g_lvl[L-1].dout[0] + g_lvl[L-1].dout[1];

`ifdef WALLACE_PIPE_OVF_EN
  logic last_mode;
  logic mode_q;
`endif

  // Valid (and mode) tags for the tree ranks in front of the output register.
  if (STAGES == 1) begin : g_tag
    assign last_valid = io.in_valid;
`ifdef WALLACE_PIPE_OVF_EN
    assign last_mode  = io.signed_mode;
`endif
  end else begin : g_tag
    logic [STAGES-2:0] vld_p;
`ifdef WALLACE_PIPE_OVF_EN
    logic [STAGES-2:0] mode_p;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= '0;
`ifdef WALLACE_PIPE_OVF_EN
        mode_p <= '0;
`endif
      end else if (advance) begin
        vld_p[0] <= io.in_valid;
        for (int k = 1; k < STAGES - 1; k++) vld_p[k] <= vld_p[k-1];
`ifdef WALLACE_PIPE_OVF_EN
        mode_p[0] <= io.signed_mode;
        for (int k = 1; k < STAGES - 1; k++) mode_p[k] <= mode_p[k-1];
`endif
      end
    end
    assign last_valid = vld_p[STAGES-2];
`ifdef WALLACE_PIPE_OVF_EN
    assign last_mode  = mode_p[STAGES-2];
`endif
  end

  // Output rank: only a valid product overwrites out, bubbles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (advance) begin
      out_valid_q <= last_valid;
      if (last_valid) out_q <= cpa;
    end
  end

`ifdef WALLACE_PIPE_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       mode_q <= 1'b0;
    else if (advance && last_valid)   mode_q <= last_mode;
  end

  // Derived only from registered out/mode, so it resets and stalls with out.
  logic [WIDTH:0] top_bits;
  assign top_bits = out_q[PW-1:WIDTH-1];
  assign io.ovf   = mode_q ? !((&top_bits) || !(|top_bits)) : (|out_q[PW-1:WIDTH]);
`endif

endmodule

// File: tb/tb_wallace_pipe_mult.sv
// tb/tb_wallace_pipe_mult.sv - directed self-checking bench for wallace_pipe_mult
module tb_wallace_pipe_mult;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  wallace_pipe_mult_if #(.WIDTH(WIDTH)) bus ();

  wallace_pipe_mult #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sm);
    longint sx;
    longint sy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Presents one operand pair and returns just after the edge that took it;
  // in_valid is left high so callers can stream back-to-back.
  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic acc;
    int   n;
    bus.a           = x;
    bus.b           = y;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic sm, input logic [63:0] exp, input logic exp_ovf);
    int n;
    bus.out_ready = 1'b1;
    push(x, y, sm);
    bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    check({tag, "_lat"}, 64'(n), 64'(STAGES));
    check(tag, bus.out, exp);
`ifdef WALLACE_PIPE_OVF_EN
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
`endif
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a product and checks it; it retires on the next edge
  // provided out_ready is high.
  task automatic collect(input string tag, input logic [63:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    check({tag, "_v"}, 64'(bus.out_valid), 64'd1);
    check(tag, bus.out, exp);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        ss [8];
  logic [63:0] se [8];
  logic [31:0] ba [4];
  logic [31:0] bb [4];
  logic        bs [4];
  logic [63:0] be [4];

  initial begin
    int cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b1;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out", bus.out, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single transactions: value, latency and (optionally) ovf.
    run_one("u15x3",     32'd15,         32'd3,          1'b0, 64'd45,                   1'b0);
    run_one("u1024x512", 32'd1024,       32'd512,        1'b0, 64'd524288,               1'b0);
    run_one("s_m1xm1",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'd1,                    1'b0);
    run_one("u_maxsq",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001,  1'b1);
    run_one("s_m3x5",    32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1,  1'b0);
    run_one("s_minsq",   32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000,  1'b1);
    run_one("s_maxsq",   32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 64'h3FFF_FFFF_0000_0001,  1'b1);
    run_one("s_minx1",   32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000,  1'b0);
    run_one("u_maxx2",   32'hFFFF_FFFF,  32'd2,          1'b0, 64'h0000_0001_FFFF_FFFE,  1'b1);
    run_one("u_7fffx2",  32'h0000_7FFF,  32'd2,          1'b0, 64'h0000_0000_0000_FFFE,  1'b0);

    // Back-to-back stream of 8 with out_ready held high.
    sa[0] = 32'd0;          sb[0] = 32'd99999;       ss[0] = 1'b0;
    sa[1] = 32'h1234_5678;  sb[1] = 32'h8765_4321;   ss[1] = 1'b0;
    for (int i = 2; i < 8; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      ss[i] = i[0];
    end
    for (int i = 0; i < 8; i++) se[i] = model(sa[i], sb[i], ss[i]);
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) push(sa[i], sb[i], ss[i]);
        bus.in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.out_valid && n < 30);
        for (int i = 0; i < 8; i++) begin
          check($sformatf("strm_v%0d", i), 64'(bus.out_valid), 64'd1);
          check($sformatf("strm_d%0d", i), bus.out, se[i]);
          @(negedge clk);
        end
        check("strm_end_v", 64'(bus.out_valid), 64'd0);
      end
    join
    @(posedge clk);
    #1;

    // Backpressure: fill the pipe, hold out_ready low, then drain.
    ba[0] = 32'd7;          bb[0] = 32'd6;       bs[0] = 1'b0;  be[0] = 64'd42;
    ba[1] = 32'd11;         bb[1] = 32'd12;      bs[1] = 1'b0;  be[1] = 64'd132;
    ba[2] = 32'hFFFF_FFF9;  bb[2] = 32'd9;       bs[2] = 1'b1;  be[2] = 64'hFFFF_FFFF_FFFF_FFC1;
    ba[3] = 32'd100000;     bb[3] = 32'd100000;  bs[3] = 1'b0;  be[3] = 64'h0000_0002_540B_E400;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(ba[i], bb[i], bs[i]);
    bus.a           = ba[3];
    bus.b           = bb[3];
    bus.signed_mode = bs[3];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp_hold_v%0d", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold_d%0d", k), bus.out, be[0]);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    fork
      begin
        push(ba[3], bb[3], bs[3]);
        bus.in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) collect($sformatf("bp_d%0d", k), be[k]);
        @(negedge clk);
        check("bp_no_dup", 64'(bus.out_valid), 64'd0);
      end
    join
    @(posedge clk);
    #1;

    // Reset with three items in flight.
    push(32'd1, 32'd2, 1'b0);
    push(32'd3, 32'd4, 1'b0);
    push(32'd5, 32'd6, 1'b0);
    bus.in_valid = 1'b0;
    check("mid_pre_v", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_v", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out", bus.out, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("mid_no_stale", 64'(cnt), 64'd0);
    check("mid_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    run_one("post_rst", 32'd1000, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FC18, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
